// File: rtl/xor_frame_checker.sv
// Streaming XOR fold over valid/ready frames, with generate and check modes.
// Reports the residual word, its parity, beat count, mismatch and overrun per frame.

module xor_gate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a ^ b;
endmodule

module xor_frame_checker #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [LW-1:0]    out_len,
  output logic             out_error,
  output logic             out_overrun
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [LW-1:0] LEN_LIMIT = LW'(MAX_LEN);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_base, acc_nxt;
  logic [LW-1:0]    cnt, cnt_nxt;
  logic             mode_q, mode_eff;
  logic             accept, close_frame;
  logic [WIDTH-1:0] xor_q;
  logic [LW-1:0]    len_q;
  logic             error_q, overrun_q;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // The first beat of a frame seeds the accumulator by folding against zero.
  assign acc_base = (state == IDLE) ? '0 : acc;

  xor_gate #(.WIDTH(WIDTH)) u_fold (
    .a (acc_base),
    .b (in_data),
    .y (acc_nxt)
  );

  assign cnt_nxt     = (state == IDLE) ? LW'(1) : cnt + LW'(1);
  assign mode_eff    = (state == IDLE) ? mode : mode_q;
  assign close_frame = accept && (in_last || (cnt_nxt == LEN_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the next-state value is defaulted before the case so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ACCUM: if (accept) state_nxt = close_frame ? DONE : ACCUM;
      DONE:        if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      xor_q     <= '0;
      len_q     <= '0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (accept) begin
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_eff;
      // Results load on the final beat's edge and are held until the next close.
      if (close_frame) begin
        xor_q     <= acc_nxt;
        len_q     <= cnt_nxt;
        error_q   <= mode_eff && (|acc_nxt);
        overrun_q <= !in_last;
      end
    end
  end

  assign out_xor     = xor_q;
  assign out_parity  = ^xor_q;
  assign out_len     = len_q;
  assign out_error   = error_q;
  assign out_overrun = overrun_q;

endmodule

// File: tb/tb_xor_frame_checker.sv
// Randomised and directed bench for xor_frame_checker (WIDTH=8, MAX_LEN=4),
// scored against a frame-level model that splits a beat stream into results.

module tb_xor_frame_checker;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_xor;
  logic             out_parity;
  logic [LW-1:0]    out_len;
  logic             out_error;
  logic             out_overrun;

  always #5 clk = ~clk;

  xor_frame_checker #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .mode        (mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_xor     (out_xor),
    .out_parity  (out_parity),
    .out_len     (out_len),
    .out_error   (out_error),
    .out_overrun (out_overrun)
  );

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic             p;
    logic [LW-1:0]    len;
    logic             err;
    logic             ovr;
  } res_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             mode;
  } beat_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  beat_t  stim[$];
  bit     closes[$];
  res_t   exp_q[$];

  function automatic res_t mk(input logic [WIDTH-1:0] x, input int len,
                              input logic err, input logic ovr);
    res_t r;
    r.x   = x;
    r.p   = ^x;
    r.len = LW'(len);
    r.err = err;
    r.ovr = ovr;
    return r;
  endfunction

  function automatic beat_t bt(input logic [WIDTH-1:0] d, input logic l, input logic m);
    beat_t b;
    b.data = d;
    b.last = l;
    b.mode = m;
    return b;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.x   = out_xor;
    r.p   = out_parity;
    r.len = out_len;
    r.err = out_error;
    r.ovr = out_overrun;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame model: a frame ends on in_last or after MAX_LEN beats; its mode is
  // that of its first beat and check-mode frames flag any nonzero residual.
  task automatic build_expect();
    logic [WIDTH-1:0] x;
    int               n;
    logic             md;
    x = '0;
    n = 0;
    md = 1'b0;
    exp_q.delete();
    closes.delete();
    foreach (stim[i]) begin
      if (n == 0) md = stim[i].mode;
      x ^= stim[i].data;
      n++;
      if (stim[i].last || n == MAX_LEN) begin
        exp_q.push_back(mk(x, n, md && (x != '0), !stim[i].last));
        closes.push_back(1'b1);
        x = '0;
        n = 0;
      end else begin
        closes.push_back(1'b0);
      end
    end
  endtask

  task automatic run_stream(input string name, input int ready_pct, input int valid_pct);
    int   idx, cyc, budget;
    bit   pend_close, have_cur, post_hs, acc_now, cl_now, hs_now;
    res_t cur;
    idx = 0;
    cyc = 0;
    pend_close = 0;
    have_cur = 0;
    post_hs = 0;
    cur = '0;
    build_expect();
    budget = 20 * stim.size() + 200;
    while ((idx < stim.size() || have_cur || exp_q.size() != 0) && cyc < budget) begin
      if (idx < stim.size() && $urandom_range(0, 99) < valid_pct) begin
        in_valid = 1'b1;
        in_data  = stim[idx].data;
        in_last  = stim[idx].last;
        mode     = stim[idx].mode;
      end else begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_last  = 1'($urandom);
        mode     = 1'($urandom);
      end
      if (pend_close) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s latency: out_valid=%b required 1 one cycle after final beat", name, out_valid);
        end
      end
      if (post_hs) begin
        n_checks++;
        if (out_valid !== 1'b0 || observed() !== cur) begin
          n_fail++;
          $display("FAIL %s after_handshake: out_valid=%b res=%h required 0 / %h", name, out_valid, observed(), cur);
        end
      end
      if (out_valid === 1'b1) begin
        if (!have_cur) begin
          n_checks++;
          if (!pend_close || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_result: res=%h pend=%0d queued=%0d", name, observed(), pend_close, exp_q.size());
          end
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          n_checks++;
          if (observed() !== cur || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s result: res=%h in_ready=%b required %h / 0", name, observed(), in_ready, cur);
          end
        end
      end
      out_ready = (out_valid === 1'b1) && ($urandom_range(0, 99) < ready_pct);
      acc_now = in_valid && (in_ready === 1'b1);
      cl_now  = acc_now && closes[idx];
      hs_now  = (out_valid === 1'b1) && out_ready && have_cur;
      step();
      cyc++;
      if (acc_now) idx++;
      pend_close = cl_now;
      post_hs    = hs_now;
      if (hs_now) have_cur = 0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (cyc >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: beats_sent=%0d of %0d results_left=%0d", name, idx, stim.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    mode = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (observed() !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: res=%h out_valid=%b required 0", observed(), out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic check_held(input string name, input res_t exp);
    n_checks++;
    if (observed() !== exp || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s held: res=%h out_valid=%b required %h / 0", name, observed(), out_valid, exp);
    end
  endtask

  task automatic test_generate();
    stim = '{bt(8'h12, 0, 0), bt(8'h34, 0, 0), bt(8'h56, 1, 0)};
    run_stream("generate", 100, 100);
    check_held("generate", mk(8'h70, 3, 1'b0, 1'b0));
  endtask

  task automatic test_check_mode();
    stim = '{bt(8'h12, 0, 1), bt(8'h34, 0, 1), bt(8'h26, 1, 1),
             bt(8'h12, 0, 1), bt(8'h34, 0, 1), bt(8'h27, 1, 1)};
    run_stream("check_mode", 70, 100);
    check_held("check_mode", mk(8'h01, 3, 1'b1, 1'b0));
  endtask

  task automatic test_single_beat();
    stim = '{bt(8'hFF, 1, 0)};
    run_stream("single_beat", 100, 100);
    check_held("single_beat", mk(8'hFF, 1, 1'b0, 1'b0));
  endtask

  task automatic test_overrun();
    stim = '{bt(8'h01, 0, 0), bt(8'h02, 0, 0), bt(8'h04, 0, 0), bt(8'h08, 0, 0),
             bt(8'h10, 1, 0)};
    run_stream("overrun", 40, 100);
    check_held("overrun", mk(8'h10, 1, 1'b0, 1'b0));
  endtask

  task automatic test_backpressure();
    res_t exp;
    exp = mk(8'h33, 2, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data = 8'h3C;
    in_last = 1'b0;
    mode = 1'b0;
    step();
    in_data = 8'h0F;
    in_last = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      in_data  = WIDTH'($urandom);
      in_last  = 1'($urandom);
      mode     = 1'($urandom);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b res=%h required 1/0/%h", i, out_valid, in_ready, observed(), exp);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== exp) begin
      n_fail++;
      $display("FAIL backpressure_release: valid=%b ready=%b res=%h required 0/1/%h", out_valid, in_ready, observed(), exp);
    end
  endtask

  task automatic test_reset_midframe();
    in_valid = 1'b1;
    in_data = 8'h5A;
    in_last = 1'b0;
    mode = 1'b1;
    step();
    in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (observed() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midframe: res=%h valid=%b ready=%b required 0/0/1", observed(), out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    stim = '{bt(8'hAA, 1, 0)};
    run_stream("after_reset", 100, 100);
    check_held("after_reset", mk(8'hAA, 1, 1'b0, 1'b0));
  endtask

  task automatic test_reset_in_done();
    in_valid = 1'b1;
    in_data = 8'h81;
    in_last = 1'b1;
    mode = 1'b1;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (observed() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_done: res=%h valid=%b ready=%b required 0/0/1", observed(), out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    int               len;
    logic             md;
    logic [WIDTH-1:0] x, d;
    stim.delete();
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 9);
      md  = 1'($urandom_range(0, 1));
      x   = '0;
      for (int b = 0; b < len; b++) begin
        d = WIDTH'($urandom);
        if (b == len - 1 && md && len <= MAX_LEN && $urandom_range(0, 1) == 1) d = x;
        x ^= d;
        stim.push_back(bt(d, b == len - 1, (b == 0) ? md : 1'($urandom_range(0, 1))));
      end
    end
    run_stream("random", 60, 80);
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check_mode();
    test_single_beat();
    test_overrun();
    test_backpressure();
    test_reset_midframe();
    test_reset_in_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_frame_checker.md
Name: xor_frame_checker

Overview:
Streaming, parametrised XOR engine that folds a frame of WIDTH-bit words into one running XOR word. It is built on the team's basic xor gate. It has two modes. In generate mode it produces a frame check word. In check mode it verifies a frame whose last beat is the check word. It sits between a valid/ready data source and a result consumer, and it reports the XOR word, reduction parity, beat count, mismatch and overrun.

Parameters:
WIDTH, 8, data word width in bits (>=1)
MAX_LEN, 16, maximum beats per frame (>=1); reaching it forces frame termination
LW, $clog2(MAX_LEN+1), width of beat counter and out_len (derived; do not override)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  input word
in_last  input  1  marks final beat of frame
mode  input  1  0 = generate, 1 = check; sampled on first beat of frame only
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_xor  output  WIDTH  XOR of all accepted beats of frame
out_parity  output  1  reduction XOR of out_xor
out_len  output  LW  number of beats in frame
out_error  output  1  check mode: out_xor != 0; generate mode: always 0
out_overrun  output  1  frame forced closed at MAX_LEN without in_last

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: state IDLE; accumulator, counter and mode latch cleared. Outputs: out_valid=0, out_xor=0, out_parity=0, out_len=0, out_error=0, out_overrun=0. in_ready=1 in the first cycle after rst deasserts.
- Beat accepted when in_valid & in_ready.
- States:
  - IDLE: no frame open; in_ready=1.
  - ACCUM: frame open; in_ready=1.
  - DONE: result presented; out_valid=1; in_ready=0.
- IDLE, beat accepted: acc <= in_data; cnt <= 1; mode latched.
  - If in_last=1 or MAX_LEN==1, go to DONE; otherwise go to ACCUM.
- ACCUM, beat accepted: acc <= acc ^ in_data; cnt <= cnt+1.
  - Close the frame (go to DONE) if in_last=1 or cnt+1==MAX_LEN.
- Frame close: result registers load in the same edge as the final beat. out_valid rises the next cycle; latency is 1 cycle from final beat to result.
- Overrun: frame closed by the counter while in_last=0 on that beat sets out_overrun=1. If in_last=1 on the MAX_LEN-th beat, out_overrun=0.
- Check mode: the last beat is the check word and is included in the XOR. A correct frame leaves residual 0; out_error = |out_xor.
- DONE:
  - Result outputs are held stable while out_ready=0.
  - out_valid & out_ready moves to IDLE; out_valid drops the next cycle.
  - out_* hold their last values after the handshake (not cleared).
- in_data, in_last and in_valid are ignored while in_ready=0. mode changes mid-frame are ignored.
- Throughput: 1 beat/cycle inside a frame. There is at least one no-accept cycle (DONE) between frames.
- Reset mid-frame or in DONE: partial frame discarded, no result emitted, all outputs return to reset values.
- Counter never wraps; its maximum value is MAX_LEN.

Test Plan:
1. Generate, WIDTH=8, MAX_LEN=4: beats 0x12, 0x34, 0x56(last) -> one cycle later out_valid=1, out_xor=0x70, out_parity=1, out_len=3, out_error=0, out_overrun=0.
2. Check mode: 0x12, 0x34, 0x26(last) -> out_xor=0x00, out_error=0. Next frame 0x12, 0x34, 0x27(last) -> out_xor=0x01, out_parity=1, out_error=1.
3. Single-beat frame: 0xFF with in_last in IDLE -> out_xor=0xFF, out_parity=0, out_len=1, DONE reached directly.
4. Overrun, MAX_LEN=4: beats 0x01, 0x02, 0x04, 0x08, 0x10 with in_last=0 -> result after 4th beat: out_xor=0x0F, out_len=4, out_overrun=1. 0x10 is held off (in_ready=0) until out_ready, then starts a new frame.
5. Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid and all out_* stable, in_ready=0, in_valid pulses ignored. Assert out_ready -> IDLE next cycle.
6. Reset mid-frame after 2 beats -> all outputs 0, in_ready=1 after release. Then frame 0xAA(last) -> out_xor=0xAA, out_len=1, no stale accumulation.
